// File: rtl/key_event_decoder.sv
// Turns one debounced key level into single-cycle short-press, long-press and
// auto-repeat events, plus a registered "key is held" flag.
module key_event_decoder #(
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned LONG_TICKS   = 50_000_000,
    parameter int unsigned REPEAT_TICKS = 10_000_000,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_held
);

    localparam int unsigned MaxTicks = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned CntW     = $clog2(MaxTicks + 1);

    localparam logic [CntW-1:0] LongLast = CntW'(LONG_TICKS - 1);
    localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_TICKS - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPress = 2'd1,
        StHold  = 2'd2
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            p_q;
    logic            pressed;

    assign pressed = ACTIVE_LOW ? ~key_in : key_in;

    // The counter is cleared on every terminal match, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            p_q          <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            p_q          <= pressed;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (p_q) begin
                        state_q  <= StPress;
                        cnt_q    <= CntOne;
                        key_held <= 1'b1;
                    end
                end
                StPress: begin
                    if (!p_q) begin
                        short_pulse <= 1'b1;
                        state_q     <= StIdle;
                        cnt_q       <= '0;
                        key_held    <= 1'b0;
                    end else if (cnt_q == LongLast) begin
                        long_pulse <= 1'b1;
                        state_q    <= StHold;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StHold: begin
                    // Release takes priority over a coincident repeat.
                    if (!p_q) begin
                        state_q  <= StIdle;
                        cnt_q    <= '0;
                        key_held <= 1'b0;
                    end else if (cnt_q == RepLast) begin
                        repeat_pulse <= REPEAT_EN;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    cnt_q    <= '0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: three decoders (default, repeat disabled, active-high key)
// share one press stimulus; a negedge monitor pops expected events per instance.
module tb_key_event_decoder;

    localparam int L = 8;
    localparam int R = 4;

    typedef struct {
        int kind;  // 0 short, 1 long, 2 repeat
        int at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pressed = 1'b0;
    logic       key_lo;
    logic       key_hi;
    logic [2:0] sp, lp, rp, kh;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[3][$];

    assign key_lo = ~pressed;
    assign key_hi = pressed;

    key_event_decoder #(.ACTIVE_LOW(1'b1), .LONG_TICKS(L), .REPEAT_TICKS(R), .REPEAT_EN(1'b1))
    u_main (.clk(clk), .rst_n(rst_n), .key_in(key_lo), .short_pulse(sp[0]),
            .long_pulse(lp[0]), .repeat_pulse(rp[0]), .key_held(kh[0]));

    key_event_decoder #(.ACTIVE_LOW(1'b1), .LONG_TICKS(L), .REPEAT_TICKS(R), .REPEAT_EN(1'b0))
    u_norep (.clk(clk), .rst_n(rst_n), .key_in(key_lo), .short_pulse(sp[1]),
             .long_pulse(lp[1]), .repeat_pulse(rp[1]), .key_held(kh[1]));

    key_event_decoder #(.ACTIVE_LOW(1'b0), .LONG_TICKS(L), .REPEAT_TICKS(R), .REPEAT_EN(1'b1))
    u_ahi (.clk(clk), .rst_n(rst_n), .key_in(key_hi), .short_pulse(sp[2]),
           .long_pulse(lp[2]), .repeat_pulse(rp[2]), .key_held(kh[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", name, d, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int e, input int base);
        for (int d = 0; d < 3; d++) begin
            if (!(kind == 2 && d == 1)) exp_q[d].push_back('{kind: kind, at: base + e});
        end
    endtask

    task automatic check_quiet(input string name);
        for (int d = 0; d < 3; d++) begin
            check(name, d, {29'd0, sp[d], lp[d], rp[d]}, 32'd0);
            check({name, "_held"}, d, {31'd0, kh[d]}, 32'd0);
        end
    endtask

    // Hold the key for D samples, then release for at least gap (>=1) samples.
    task automatic press(input int dur, input int gap);
        int base;
        pressed = 1'b1;
        base = cyc + 1;
        if (dur < L) begin
            push(0, dur + 1, base);
        end else begin
            push(1, L, base);
            for (int e = L + R; e <= dur; e += R) push(2, e, base);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("held_edge0", d, {31'd0, kh[d]}, 32'd0);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("held_edge1", d, {31'd0, kh[d]}, 32'd1);
        repeat (dur - 2) @(negedge clk);
        pressed = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("held_last", d, {31'd0, kh[d]}, 32'd1);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("held_idle", d, {31'd0, kh[d]}, 32'd0);
            check("queue_drained", d, exp_q[d].size(), 32'd0);
            exp_q[d].delete();
        end
    endtask

    // Monitor: every pulse must be one-hot and match the oldest expected event.
    always @(negedge clk) begin
        logic [2:0] p;
        ev_t        ev;
        int         k;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                p = {rp[d], lp[d], sp[d]};
                if (p != 3'b000) begin
                    check("pulse_onehot", d, $countones(p), 32'd1);
                    if (exp_q[d].size() == 0) begin
                        check("unexpected_pulse", d, {29'd0, p}, 32'd0);
                    end else begin
                        ev = exp_q[d].pop_front();
                        k  = p[0] ? 0 : (p[1] ? 1 : 2);
                        check("pulse_kind", d, k, ev.kind);
                        check("pulse_cycle", d, cyc, ev.at);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_quiet("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("after_reset");

        press(3, 1);  settle(4);   // short press
        press(7, 1);  settle(4);   // longest short press
        press(8, 1);  settle(4);   // shortest long press
        press(20, 1); settle(4);   // long + repeats at 12, 16, 20
        press(15, 1); settle(4);   // release on repeat edge 16
        press(2, 1);  press(3, 1); settle(4);  // back-to-back, one-sample gap

        // Reset in the middle of a held press, key kept down throughout.
        pressed = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("mid_press_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = cyc + 1;
        push(1, L, base);
        repeat (10) @(negedge clk);
        pressed = 1'b0;
        settle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
